// File: rtl/flaf_pkg.sv
// Shared definitions for the FLAF weight-update datapath: scheduler states,
// default word geometry and the rounding constant used by the MAC slice.
package flaf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_QP    = 12;
    localparam int DEF_NTAPS = 8;

    // Half an LSB of the QP-bit result: adding it before truncation rounds to nearest.
    function automatic longint unsigned rnd_half(input int qp);
        return longint'(1) << (qp - 1);
    endfunction

endpackage

// File: rtl/w_mac_slice.sv
// Combinational multiply-round-accumulate: w_o = w_i + rnd(x_i * mu_e_i),
// with the sum wrapping modulo 2^WIDTH.
module w_mac_slice
    import flaf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int QP    = DEF_QP
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] mu_e_i,
    input  logic [WIDTH-1:0] w_i,
    output logic [WIDTH-1:0] w_o
);

    localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(rnd_half(QP));

    logic signed [2*WIDTH-1:0] x_ext;
    logic signed [2*WIDTH-1:0] mu_ext;
    logic signed [2*WIDTH-1:0] prod;

    // Sign-extending both operands keeps the low 2*WIDTH product bits exact.
    assign x_ext  = {{WIDTH{x_i[WIDTH-1]}}, x_i};
    assign mu_ext = {{WIDTH{mu_e_i[WIDTH-1]}}, mu_e_i};
    assign prod   = x_ext * mu_ext;

    assign w_o = w_i + WIDTH'((prod + RND) >>> QP);

endmodule

// File: rtl/w_update_seq.sv
// Serial weight-update scheduler: on each accepted mu*error sample it sweeps
// all taps through one shared MAC slice, updating the NTAPS-entry weight bank.
module w_update_seq
    import flaf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int QP    = DEF_QP,
    parameter int NTAPS = DEF_NTAPS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     err_valid,
    output logic                     err_ready,
    input  logic [WIDTH-1:0]         mu_error,
    output logic [$clog2(NTAPS)-1:0] x_addr,
    input  logic [WIDTH-1:0]         x_data,
    input  logic [$clog2(NTAPS)-1:0] w_rd_addr,
    output logic [WIDTH-1:0]         w_rd_data,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
    localparam logic [AW-1:0] PREF_LIM = AW'(NTAPS - 2);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     x_addr_q, x_addr_d;
    logic [WIDTH-1:0]  mu_q, mu_d;
    logic [WIDTH-1:0]  w_q [NTAPS];
    logic [WIDTH-1:0]  w_new;
    logic              w_we;
    logic              xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            x_addr_q <= '0;
            mu_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_addr_q <= x_addr_d;
            mu_q     <= mu_d;
        end
    end

    assign xfer = err_valid && err_ready;

    // x_addr runs one tap ahead of idx so the registered buffer read lines up.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_addr_d = x_addr_q;
        mu_d     = mu_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d  = ST_PRIME;
                    x_addr_d = '0;
                    mu_d     = mu_error;
                end
            end
            ST_PRIME: begin
                state_d  = ST_RUN;
                idx_d    = '0;
                x_addr_d = AW'(1);
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
                if (idx_q < PREF_LIM) begin
                    x_addr_d = idx_q + AW'(2);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        err_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        w_we      = 1'b0;
        case (state_q)
            ST_IDLE:  err_ready = !clear;
            ST_PRIME: busy = 1'b1;
            ST_RUN: begin
                busy = 1'b1;
                w_we = !clear;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = !clear;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    w_mac_slice #(
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_mac (
        .x_i    (x_data),
        .mu_e_i (mu_q),
        .w_i    (w_q[idx_q]),
        .w_o    (w_new)
    );

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_wbank
            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    w_q[gi] <= '0;
                end else if (w_we && (idx_q == AW'(gi))) begin
                    w_q[gi] <= w_new;
                end
            end
        end
    endgenerate

    assign w_rd_data = w_q[w_rd_addr];
    assign x_addr    = x_addr_q;

endmodule

// File: tb/tb_w_update_seq.sv
// Bench for w_update_seq: table vectors, directed corner sequences and random
// sweeps checked against an arithmetic model of the weight update.
module tb_w_update_seq;

    localparam int W  = 16;
    localparam int QP = 12;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          err_valid;
    logic          err_ready;
    logic [W-1:0]  mu_error;
    logic [AW-1:0] x_addr;
    logic [W-1:0]  x_data;
    logic [AW-1:0] w_rd_addr;
    logic [W-1:0]  w_rd_data;
    logic          busy;
    logic          done;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [W-1:0] xbuf    [N];
    logic [W-1:0] model_w [N];

    typedef struct {
        bit           do_clear;
        logic [W-1:0] x;
        logic [W-1:0] mu;
        logic [W-1:0] exp_w;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    // Expansion buffer: one-cycle registered read.
    always @(posedge clk) x_data <= xbuf[x_addr];

    w_update_seq #(.WIDTH(W), .QP(QP), .NTAPS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .mu_error  (mu_error),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .w_rd_addr (w_rd_addr),
        .w_rd_data (w_rd_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [W-1:0] upd(input logic [W-1:0] w, input logic [W-1:0] x,
                                         input logic [W-1:0] mu);
        longint p;
        longint d;
        p = longint'($signed(x)) * longint'($signed(mu));
        d = (p + (longint'(1) <<< (QP - 1))) >>> QP;
        return w + W'(d);
    endfunction

    task automatic model_apply(input logic [W-1:0] mu);
        for (int k = 0; k < N; k++) model_w[k] = upd(model_w[k], xbuf[k], mu);
    endtask

    task automatic model_zero();
        for (int k = 0; k < N; k++) model_w[k] = '0;
    endtask

    task automatic check_all(input string name);
        for (int k = 0; k < N; k++) begin
            w_rd_addr = AW'(k);
            #1;
            check($sformatf("%s_w%0d", name, k), {16'd0, w_rd_data}, {16'd0, model_w[k]});
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_zero();
    endtask

    // Present a sample and wait (bounded) for it to be taken; returns #1 after the transfer edge.
    task automatic start(input logic [W-1:0] mu);
        int waited;
        waited = 0;
        @(negedge clk); err_valid = 1'b1; mu_error = mu;
        while (!err_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept", {31'd0, err_ready}, 32'd1);
        @(posedge clk); #1;
        err_valid = 1'b0;
    endtask

    task automatic sweep(input logic [W-1:0] mu);
        logic [W-1:0] old_w [N];
        int busy_n, done_n, done_at, mk, mj;
        busy_n = 0; done_n = 0; done_at = 0;
        mk = $urandom_range(0, N - 1);
        mj = $urandom_range(0, N - 1);
        old_w = model_w;
        model_apply(mu);
        start(mu);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
            if (n == 2 + mk) begin
                w_rd_addr = AW'(mj);
                #1;
                check($sformatf("mid_read k%0d j%0d", mk, mj), {16'd0, w_rd_data},
                      {16'd0, (mj < mk) ? model_w[mj] : old_w[mj]});
            end
        end
        check("done_latency", done_at, 10);
        check("done_pulses", done_n, 1);
        check("busy_cycles", busy_n, 10);
        check_all("sweep");
    endtask

    initial begin
        int bad, done_n;
        reset = 1'b1; clear = 1'b0; err_valid = 1'b0; mu_error = '0; w_rd_addr = '0;
        for (int k = 0; k < N; k++) xbuf[k] = '0;
        model_zero();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_ready", {31'd0, err_ready}, 1);
        check("rst_xaddr", {29'd0, x_addr}, 0);
        check_all("rst");

        // Table vectors: uniform x across taps, expected weight constant for every tap.
        vecs[0] = '{1'b1, 16'h1000, 16'h0800, 16'h0800};
        vecs[1] = '{1'b1, 16'h0001, 16'h0800, 16'h0001};
        vecs[2] = '{1'b0, 16'h0001, 16'h07FF, 16'h0001};
        vecs[3] = '{1'b1, 16'hF000, 16'h0800, 16'hF800};
        vecs[4] = '{1'b0, 16'hF000, 16'hF800, 16'h0000};
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_clear) pulse_clear();
            for (int k = 0; k < N; k++) xbuf[k] = vecs[v].x;
            sweep(vecs[v].mu);
            for (int k = 0; k < N; k++) begin
                w_rd_addr = AW'(k);
                #1;
                check($sformatf("vec%0d_w%0d", v, k), {16'd0, w_rd_data}, {16'd0, vecs[v].exp_w});
            end
        end

        // Wrap: tap 3 driven to 0x7FFF, then one more LSB.
        pulse_clear();
        for (int k = 0; k < N; k++) xbuf[k] = '0;
        xbuf[3] = 16'h1000;
        sweep(16'h7FFF);
        sweep(16'h0001);
        w_rd_addr = 3'd3; #1;
        check("wrap_w3", {16'd0, w_rd_data}, 32'h8000);

        // Backpressure: valid held through a sweep, mu changes after first transfer.
        pulse_clear();
        for (int k = 0; k < N; k++) xbuf[k] = W'($urandom);
        model_apply(16'h0321);
        model_apply(16'hFA10);
        @(negedge clk); err_valid = 1'b1; mu_error = 16'h0321;
        #1;
        check("bp_ready0", {31'd0, err_ready}, 1);
        @(posedge clk); #1; mu_error = 16'hFA10;
        bad = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (err_ready) bad++;
        end
        check("bp_ready_low_while_busy", bad, 0);
        @(negedge clk);
        check("bp_ready_after_done", {31'd0, err_ready}, 1);
        @(posedge clk); #1; err_valid = 1'b0;
        done_n = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("bp_second_done", done_n, 1);
        check_all("bp");

        // Sample offered while clear is high is ignored.
        @(negedge clk); clear = 1'b1; err_valid = 1'b1; mu_error = 16'h1234;
        #1;
        check("clr_ready", {31'd0, err_ready}, 0);
        @(negedge clk); clear = 1'b0; err_valid = 1'b0;
        model_zero();
        #1;
        check("clr_no_accept", {31'd0, busy}, 0);
        check_all("clr_hold");

        // clear during RUN idx=4.
        for (int k = 0; k < N; k++) xbuf[k] = 16'h1000;
        start(16'h0400);
        for (int n = 1; n <= 6; n++) @(negedge clk);
        check("abort_clr_busy", {31'd0, busy}, 1);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_zero();
        #1;
        check("abort_clr_idle", {31'd0, busy}, 0);
        check("abort_clr_ready", {31'd0, err_ready}, 1);
        done_n = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_clr_nodone", done_n, 0);
        check_all("abort_clr");

        // reset during RUN idx=2.
        start(16'h0400);
        for (int n = 1; n <= 4; n++) @(negedge clk);
        check("abort_rst_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_zero();
        #1;
        check("abort_rst_idle", {31'd0, busy}, 0);
        check("abort_rst_ready", {31'd0, err_ready}, 1);
        check("abort_rst_xaddr", {29'd0, x_addr}, 0);
        done_n = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_rst_nodone", done_n, 0);
        check_all("abort_rst");

        // Random sweeps against the model.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) pulse_clear();
            for (int k = 0; k < N; k++) xbuf[k] = W'($urandom);
            sweep(W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
